serial_addsub_ctrl: RTL and testbench
=====================================

Name: serial_addsub_ctrl

Overview:
- Bit-serial adder/subtractor controller that time-multiplexes a single 1-bit full-adder cell over WIDTH cycles to add or subtract two WIDTH-bit operands.
- Handles operand capture, LSB-first shifting, carry storage, bit counting, result assembly and a start/done handshake.
- Sits between the processor's ALU sequencing logic and the ripple adder cell.
- Trades latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result, cout and ovf valid.
- result  output  WIDTH  sum/difference; held until the next accepted start.
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: async, active-high. While reset is high: state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; internal shift registers, carry flop and counter = 0. Asserting reset mid-operation aborts immediately; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - a_sr<=a; b_sr<=(op_sub ? ~b : b); carry<=op_sub; cnt<=0; state->RUN.
  - result/cout/ovf keep their old values until DONE entry.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Full-adder cell inputs are a_sr[0], b_sr[0], carry.
  - s = a_sr[0]^b_sr[0]^carry; co = majority(a_sr[0], b_sr[0], carry).
  - r_sr <= {s, r_sr[WIDTH-1:1]} (LSB-first, fills from the MSB end).
  - a_sr, b_sr shift right by 1; carry<=co; cnt<=cnt+1.
  - When cnt==WIDTH-1 (MSB processed this edge): result<={s, r_sr[WIDTH-1:1]}; cout<=co; ovf<=carry^co (carry-in to MSB XOR carry-out); state->DONE.
- DONE: done=1 for exactly one cycle; state->IDLE on the next edge.
- start is ignored in RUN and DONE; no queuing.
- A start in the first IDLE cycle after DONE is accepted, so back-to-back operations issue every WIDTH+2 cycles.
- Latency: start sampled at edge E0; RUN covers edges E1..EW; done is high during the cycle following edge EW, i.e. done is visible WIDTH cycles after E0.
- busy: 1 in RUN and DONE, 0 in IDLE.
- done and busy decode from registered state; no combinational path from any input to any output.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Subtract is implemented as a + ~b + 1.
- Operand inputs may change freely after the start edge without affecting the operation in flight.

Test Plan:
- WIDTH=8, add 0x05+0x03 -> result=0x08, cout=0, ovf=0; done exactly 8 cycles after the start edge, for one cycle; busy high for 9 cycles.
- Add 0x7F+0x01 -> result=0x80, cout=0, ovf=1. Add 0xFF+0x01 -> result=0x00, cout=1, ovf=0.
- Subtract 0x05-0x07 -> result=0xFE, cout=0 (borrow), ovf=0. Subtract 0x80-0x01 -> result=0x7F, cout=1, ovf=1.
- Start pulsed, then start held high with different a/b/op_sub throughout RUN -> only the first operation runs, with its original result. Start held high through DONE -> a second operation begins in the IDLE cycle after DONE.
- Assert reset at cnt=4 of an operation -> outputs clear immediately with no clock edge required; no done pulse. After release, 0x10+0x20 -> 0x30 with normal latency.
- Result-hold check: after done, change a/b without start for 20 cycles -> result, cout and ovf unchanged.

Source files
------------

// File: rtl/serial_addsub_ctrl_if.sv
// Start/operand request and result/status return bundle between the ALU
// sequencer (master) and the bit-serial add/sub controller (slave).
interface serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract: one full-adder cell reused LSB-first over WIDTH cycles.
// Result in WIDTH cycles from the start edge; start is ignored while busy.
module serial_addsub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  serial_addsub_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  // Only the upper WIDTH-1 partial-sum bits are kept; the newest bit joins at the MSB.
  logic [WIDTH-2:0] r_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic             sum_d;
  logic             carry_d;
  logic [WIDTH-1:0] r_full_d;
  logic             last_bit;

  assign sum_d    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign carry_d  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign r_full_d = {sum_d, r_sr_q};
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      r_sr_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            // Subtract as a + ~b + 1: invert B and seed the carry with 1.
            a_sr_q  <= bus.a;
            b_sr_q  <= bus.op_sub ? ~bus.b : bus.b;
            carry_q <= bus.op_sub;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr_q  <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          r_sr_q  <= r_full_d[WIDTH-1:1];
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            result_q <= r_full_d;
            cout_q   <= carry_d;
            ovf_q    <= carry_q ^ carry_d;
            state_q  <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Randomized and directed bench for serial_addsub_ctrl against an arithmetic reference model.
module tb_serial_addsub_ctrl;
  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  serial_addsub_ctrl_if #(.WIDTH(W)) bus ();

  serial_addsub_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: cycles of busy remaining, plus pending and visible results.
  int           m_left = 0;
  logic [W-1:0] m_res  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic [W-1:0] p_res  = '0;
  logic         p_cout = 1'b0;
  logic         p_ovf  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0;
      m_res  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_left == 0) begin
      if (bus.start) begin
        int ua, ub, sa, sb, sv;
        ua = int'(bus.a);
        ub = int'(bus.b);
        sa = (ua >= MOD / 2) ? ua - MOD : ua;
        sb = (ub >= MOD / 2) ? ub - MOD : ub;
        if (bus.op_sub) begin
          p_res  = W'(ua - ub);
          p_cout = (ua >= ub);
          sv     = sa - sb;
        end else begin
          p_res  = W'(ua + ub);
          p_cout = (ua + ub >= MOD);
          sv     = sa + sb;
        end
        p_ovf  = (sv >= MOD / 2) || (sv < -(MOD / 2));
        m_left = W + 1;
      end
    end else begin
      m_left--;
      if (m_left == 1) begin
        m_res  = p_res;
        m_cout = p_cout;
        m_ovf  = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", bus.busy, m_left != 0);
      chk("done", bus.done, m_left == 1);
      chk("result", bus.result, m_res);
      chk("cout", bus.cout, m_cout);
      chk("ovf", bus.ovf, m_ovf);
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    chk("idle_timeout", bus.busy, 1'b0);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic sub,
                        input logic [W-1:0] er, input logic ec, input logic eo);
    int n, bc;
    bit seen;
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.op_sub = sub;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom);
    @(negedge clk);
    bc = bus.busy ? 1 : 0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", seen, 1'b1);
    chk("latency", n, W);
    chk("lit_result", bus.result, er);
    chk("lit_cout", bus.cout, ec);
    chk("lit_ovf", bus.ovf, eo);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 1'b0);
    chk("busy_len", bc, W + 1);
  endtask

  initial begin
    int n;
    bit seen;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.a = '0; bus.b = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start held high with shifting operands, then through DONE into a second op.
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.op_sub = 1'b0;
    @(posedge clk);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom);
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else @(posedge clk);
    end
    chk("hold_done_seen", seen, 1'b1);
    chk("hold_result", bus.result, 8'h33);
    chk("hold_cout", bus.cout, 1'b0);
    bus.a = 8'h40; bus.b = 8'h02; bus.op_sub = 1'b1;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk("b2b_gap", n, W + 2);
    chk("b2b_result", bus.result, 8'h3E);
    chk("b2b_cout", bus.cout, 1'b1);
    chk("b2b_ovf", bus.ovf, 1'b0);

    // Abort mid-operation with reset; clears must appear without a clock edge.
    wait_idle();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 8'h55; bus.b = 8'h11; bus.op_sub = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_result", bus.result, 0);
    chk("abort_cout", bus.cout, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(posedge clk);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

    // Operands wiggle without start; outputs must hold.
    repeat (20) begin
      @(posedge clk); #1;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.op_sub = 1'($urandom);
    end
    @(negedge clk);
    chk("hold_res", bus.result, 8'h30);
    chk("hold_cout2", bus.cout, 1'b0);
    chk("hold_ovf", bus.ovf, 1'b0);

    // Random traffic: start asserted most cycles, exercising ignored and back-to-back starts.
    repeat (1500) begin
      @(posedge clk); #1;
      bus.start  = ($urandom_range(0, 2) != 0);
      bus.a      = W'($urandom);
      bus.b      = W'($urandom);
      bus.op_sub = 1'($urandom);
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
